mxv_sequencer: RTL

MXV_SEQUENCER -- requirements
Module: mxv_sequencer

---
 rtl/mxv_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mxv_sequencer.sv
// rtl/mxv_sequencer.sv - matrix-vector pass sequencer: clear, column feed, result push (optional stall counter: MXV_SEQ_STALL_CNT_EN)
module mxv_sequencer #(
    parameter int MAX_N = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  n_size,
    input  logic        fifo_a_empty,
    input  logic        result_full,
    output logic        rst_processor,
    output logic        pop_a_v,
    output logic        push_result,
    output logic [3:0]  processor_number,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_PUSH,
        S_DONE
    } state_t;

    localparam logic [4:0] MAX_N_L = 5'(MAX_N);

    state_t     state_q, state_d;
    logic [3:0] n_q, n_d;
    logic [3:0] col_q, col_d;
    logic [3:0] proc_q, proc_d;
    logic       accept;

    // A start is only taken from IDLE and only for a dimension the array can hold.
    assign accept = (state_q == S_IDLE) && start && (n_size != 4'd0)
                    && ({1'b0, n_size} <= MAX_N_L);

    // State, latched dimension and the column/processor counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= 4'd0;
            col_q   <= 4'd0;
            proc_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            col_q   <= col_d;
            proc_q  <= proc_d;
        end
    end

    // Next-state and Moore/Mealy outputs; pops and pushes follow FIFO flow control directly.
    always_comb begin
        state_d          = state_q;
        n_d              = n_q;
        col_d            = col_q;
        proc_d           = proc_q;
        rst_processor    = 1'b0;
        pop_a_v          = 1'b0;
        push_result      = 1'b0;
        processor_number = 4'd0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    n_d     = n_size;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy          = 1'b1;
                rst_processor = 1'b1;
                col_d         = 4'd0;
                state_d       = S_FEED;
            end
            S_FEED: begin
                busy    = 1'b1;
                pop_a_v = !fifo_a_empty;
                if (pop_a_v) begin
                    col_d = col_q + 4'd1;
                    if (col_q == n_q - 4'd1) begin
                        proc_d  = 4'd0;
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                busy             = 1'b1;
                push_result      = !result_full;
                processor_number = proc_q;
                if (push_result) begin
                    proc_d = proc_q + 4'd1;
                    if (proc_q == n_q - 4'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MXV_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles lost to an empty source or a full sink.
    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = 16'd0;
        end else if (((state_q == S_FEED) && fifo_a_empty)
                     || ((state_q == S_PUSH) && result_full)) begin
            if (stall_q != 16'hFFFF) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
